// File: rtl/ifetch_unit_if.sv
// Bus bundle for the instruction fetch stage: imem request/response,
// redirect input and the decode-side valid/ready output.
interface ifetch_unit_if;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;

  // master: the fetch unit itself; slave: memory, branch unit and decode
  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect,
           redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect,
           redirect_pc, out_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: one imem request in flight, 2-entry output FIFO
// of {instr, pc}, redirect flushes the FIFO and restarts fetch.
module ifetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic           clk,
  input logic           rst,
  ifetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_pc_q, req_pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;

  logic [31:0] fifo_instr_q [2];
  logic [63:0] fifo_pc_q    [2];

  logic        req_valid;
  logic        req_fire;
  logic        push;
  logic        pop;
  logic        wr_idx;
  logic        head_valid;

  // Gated by rst so no request is visible while reset is held low.
  assign req_valid  = rst && (state_q == S_IDLE) && (count_q < 2'd2) && !bus.redirect;
  assign req_fire   = req_valid && bus.imem_req_ready;
  assign head_valid = (count_q != 2'd0);

  // Flush wins over both the pop and a response arriving with the redirect.
  assign pop    = head_valid && bus.out_ready && !bus.redirect;
  assign push   = (state_q == S_WAIT) && bus.imem_rsp_valid && !bus.redirect;
  assign wr_idx = rd_ptr_q ^ count_q[0];

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          state_d  = S_WAIT;
          req_pc_d = pc_q;
          pc_d     = pc_q + 64'd4;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid)   state_d = S_IDLE;
        else if (bus.redirect)    state_d = S_DROP;
      end
      S_DROP: begin
        if (bus.imem_rsp_valid)   state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.redirect) begin
      pc_d    = {bus.redirect_pc[63:2], 2'b00};
      count_d = 2'd0;
    end else begin
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
      rd_ptr_d = rd_ptr_q ^ pop;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: FIFO storage is not reset; count_q qualifies every read, so stale
  // contents are never observable and the array stays plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_idx] <= bus.imem_rsp_data;
      fifo_pc_q[wr_idx]    <= req_pc_q;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = {pc_q[63:2], 2'b00};
  assign bus.out_valid      = head_valid;
  assign bus.out_instr      = head_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
  assign bus.out_pc         = head_valid ? fifo_pc_q[rd_ptr_q]    : 64'h0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit: a memory model with configurable latency
// and a queue-based reference model of the fetch stream.
module tb_ifetch_unit;

  localparam logic [63:0] RESET_PC = 64'h1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ifetch_unit_if bus ();

  ifetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;

  // Reference model: the expected FIFO contents, next fetch PC and the one
  // outstanding memory request (which may already be killed by a redirect).
  entry_t      exp_q[$];
  logic [63:0] model_pc;
  bit          inflight;
  bit          live;
  logic [63:0] infl_pc;
  int          mem_wait;

  int ready_pct  = 100;
  int oready_pct = 100;
  int dly_min    = 1;
  int dly_max    = 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_pc = RESET_PC;
    inflight = 1'b0;
    live     = 1'b0;
    infl_pc  = '0;
    mem_wait = 0;
  endtask

  task automatic idle_inputs();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect       = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
  endtask

  // One clock: check registered outputs, drive inputs, check the combinational
  // request, then advance the model across the rising edge.
  task automatic cycle(input bit redir, input logic [63:0] rpc);
    bit          rsp, fire, pop, push, exp_rv;
    logic [31:0] data;
    @(negedge clk);
    check("out_valid", bus.out_valid, exp_q.size() != 0);
    check("out_pc",    bus.out_pc,    exp_q.size() != 0 ? exp_q[0].pc : 64'h0);
    check("out_instr", bus.out_instr, exp_q.size() != 0 ? {32'h0, exp_q[0].instr} : 64'h0);
    rsp  = inflight && (mem_wait == 1);
    data = $urandom;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = data;
    bus.imem_req_ready = ($urandom_range(99) < ready_pct);
    bus.out_ready      = ($urandom_range(99) < oready_pct);
    bus.redirect       = redir;
    bus.redirect_pc    = rpc;
    #1;
    exp_rv = !inflight && (exp_q.size() < 2) && !redir;
    check("req_valid", bus.imem_req_valid, exp_rv);
    check("req_addr",  bus.imem_req_addr,  model_pc);
    fire = exp_rv && bus.imem_req_ready;
    pop  = bus.out_ready && (exp_q.size() != 0);
    push = rsp && live && !redir;
    @(posedge clk);
    if (rsp) inflight = 1'b0;
    else if (inflight) mem_wait--;
    if (redir) begin
      exp_q.delete();
      model_pc = {rpc[63:2], 2'b00};
      live     = 1'b0;
    end else begin
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back('{instr: data, pc: infl_pc});
    end
    if (fire) begin
      inflight = 1'b1;
      live     = 1'b1;
      infl_pc  = model_pc;
      model_pc = model_pc + 64'd4;
      mem_wait = $urandom_range(dly_max, dly_min);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 64'h0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop with no edge.
  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid,      1'b0);
    check("rst_req_valid", bus.imem_req_valid, 1'b0);
    check("rst_out_pc",    bus.out_pc,         64'h0);
    check("rst_out_instr", bus.out_instr,      64'h0);
    check("rst_req_addr",  bus.imem_req_addr,  RESET_PC);
    idle_inputs();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [63:0] rpc;
  int          guard;

  initial begin
    idle_inputs();
    model_reset();
    #1;
    check("init_req_valid", bus.imem_req_valid, 1'b0);
    check("init_out_valid", bus.out_valid,      1'b0);
    check("init_out_pc",    bus.out_pc,         64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Streaming at full speed, 1-cycle memory: fetch from RESET_PC upward.
    run(12);

    // Consumer stalled: two entries buffered and requests stop.
    oready_pct = 0;
    run(10);
    check("full_no_req", bus.imem_req_valid, 1'b0);
    check("full_valid",  bus.out_valid,      1'b1);
    oready_pct = 100;
    run(10);

    // Redirect while a 3-cycle request is in flight: its response is dropped.
    dly_min = 3; dly_max = 3;
    guard = 0;
    while (!(inflight && mem_wait == 3) && guard < 20) begin
      cycle(1'b0, 64'h0);
      guard++;
    end
    check("setup_drop", {63'h0, inflight}, 64'h1);
    cycle(1'b1, 64'h2002);
    run(20);

    // Redirect coinciding with the response and a ready consumer.
    dly_min = 1; dly_max = 1;
    guard = 0;
    while (!(inflight && mem_wait == 1) && guard < 20) begin
      cycle(1'b0, 64'h0);
      guard++;
    end
    check("setup_same", {63'h0, inflight}, 64'h1);
    cycle(1'b1, 64'h3000);
    run(10);

    // PC wrap at the top of the address space.
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    run(12);

    // Async reset mid-WAIT with one buffered entry.
    dly_min = 3; dly_max = 3; oready_pct = 0;
    guard = 0;
    while (!(inflight && exp_q.size() == 1) && guard < 40) begin
      cycle(1'b0, 64'h0);
      guard++;
    end
    check("setup_rst", exp_q.size(), 64'd1);
    async_reset();
    oready_pct = 100; dly_min = 1; dly_max = 1;
    run(10);

    // Random traffic with redirects and occasional resets.
    for (int blk = 0; blk < 12; blk++) begin
      ready_pct  = $urandom_range(100, 30);
      oready_pct = $urandom_range(100, 20);
      dly_min    = $urandom_range(2, 1);
      dly_max    = dly_min + $urandom_range(3);
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(15) == 0) begin
          rpc = ($urandom_range(3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15))
                                         : {$urandom, $urandom};
          cycle(1'b1, rpc);
        end else begin
          cycle(1'b0, 64'h0);
        end
      end
      if (blk % 4 == 3) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
